// File: rtl/cgra_cfg_pkg.sv
// Shared types and helpers for the CGRA configuration-chain loader.
package cgra_cfg_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } cfg_ld_state_t;

  // Width of a counter that must reach CHAIN_LEN itself.
  function automatic int cfg_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Width of a bit index inside one word (at least one bit).
  function automatic int cfg_idx_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/cgra_config_loader_if.sv
// Word-wide bitstream input stream and readback output stream of the loader.
interface cgra_config_loader_if
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  // Host side: supplies bitstream words, consumes readback words.
  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  // Loader side.
  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );

endinterface

// File: rtl/cgra_config_loader_rb_deser.sv
// Readback deserializer: gathers chain-tail bits into a capture word, hands
// complete words to an output register with a valid/ready handshake, and
// asks the loader to stop shifting when both registers are occupied.
module cfg_rb_deser
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W,
  parameter int IDX_W  = cfg_idx_w(CFG_WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              tail,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              word_end,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              stall,
  output logic              cap_empty
);

  logic [WORD_W-1:0] cap_word;
  logic [WORD_W-1:0] cap_nxt;
  logic              cap_full;
  logic              xfer;

  // A full capture word moves out when the output register is free or is
  // being emptied this very cycle; otherwise the chain must not advance.
  assign xfer      = cap_full && (!rb_valid || rb_ready);
  assign stall     = cap_full && rb_valid && !rb_ready;
  assign cap_empty = !cap_full;

  // Next capture word: cleared as it is handed over so that a short final
  // word reads back with its unused upper bits at zero.
  always_comb begin
    cap_nxt = xfer ? '0 : cap_word;
    if (shift) begin
      cap_nxt[bit_idx] = tail;
    end
  end

  // Capture register and its full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_word <= '0;
      cap_full <= 1'b0;
    end else begin
      cap_word <= cap_nxt;
      if (shift && word_end) begin
        cap_full <= 1'b1;
      end else if (xfer) begin
        cap_full <= 1'b0;
      end
    end
  end

  // Output register: holds a word stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else if (xfer) begin
      rb_data  <= cap_word;
      rb_valid <= 1'b1;
    end else if (rb_ready) begin
      rb_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cgra_config_loader.sv
// Serial configuration loader for a CGRA array: serializes bitstream words
// LSB first onto the chain head and deserializes the bits leaving the chain
// tail into readback words, all in the configuration clock domain.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = CFG_WORD_W
) (
  input  logic                 Config_Clock,
  input  logic                 Config_Reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  cgra_config_loader_if.slave  bus,
  output logic                 cfg_bit_out,
  output logic                 shift_en,
  input  logic                 cfg_tail_in
);

  localparam int CNT_W = cfg_cnt_w(CHAIN_LEN);
  localparam int IDX_W = cfg_idx_w(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  if (CHAIN_LEN < 1) begin : g_bad_len
    $error("cgra_config_loader: CHAIN_LEN must be at least 1");
  end

  cfg_ld_state_t     state;
  cfg_ld_state_t     state_nxt;
  logic [WORD_W-1:0] tx_sr;
  logic [CNT_W-1:0]  bits_done;
  logic [IDX_W-1:0]  word_bit;
  logic              last_chain_bit;
  logic              last_word_bit;
  logic              word_end;
  logic              stall;
  logic              cap_empty;

  // The final chain bit also closes the current word, which is how the
  // short last word of a non-multiple chain length is cut off.
  assign last_chain_bit = (bits_done == LAST_BIT);
  assign last_word_bit  = (word_bit == LAST_IDX);
  assign word_end       = last_word_bit || last_chain_bit;

  // State register.
  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    bus.cfg_ready = 1'b0;
    shift_en      = 1'b0;
    cfg_bit_out   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy          = 1'b1;
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        shift_en    = !stall;
        cfg_bit_out = tx_sr[0];
        if (!stall) begin
          if (last_chain_bit) begin
            state_nxt = ST_DRAIN;
          end else if (last_word_bit) begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // With no capture pending, the word being taken is the final one.
        if (bus.rb_valid && bus.rb_ready && cap_empty) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transmit shift register and session bit counters.
  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      tx_sr     <= '0;
      bits_done <= '0;
      word_bit  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        bits_done <= '0;
        word_bit  <= '0;
      end else if (state == ST_FETCH && bus.cfg_valid) begin
        tx_sr    <= bus.cfg_data;
        word_bit <= '0;
      end else if (shift_en) begin
        tx_sr     <= tx_sr >> 1;
        bits_done <= bits_done + CNT_W'(1);
        word_bit  <= word_bit + IDX_W'(1);
      end
    end
  end

  cfg_rb_deser #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_rb_deser (
    .clk       (Config_Clock),
    .rst_n     (Config_Reset),
    .shift     (shift_en),
    .tail      (cfg_tail_in),
    .bit_idx   (word_bit),
    .word_end  (word_end),
    .rb_data   (bus.rb_data),
    .rb_valid  (bus.rb_valid),
    .rb_ready  (bus.rb_ready),
    .stall     (stall),
    .cap_empty (cap_empty)
  );

endmodule
